alu_sequencer: RTL and testbench

- Multi-cycle controller directly upstream of the 8-bit ALU: accepts an operation request, latches operands and mode, and drives the ALU's operand, mode and enable inputs (ee, eo).
- Samples the ALU's tristate result and its flag outputs, and holds them in a result register and a flags register for the rest of the datapath.
- Replaces ad-hoc control-word sequencing of the ALU with a start/busy/done handshake.

---
 rtl/alu_sequencer.sv | 127 ++++++++++++
 tb/tb_alu_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Start/busy/done front end for the 8-bit ALU: latches a request, sequences the ALU
// enables, and registers the tristate result and flags for the rest of the datapath.
module alu_sequencer #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned MODE_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MODE_W-1:0] op,
  input  logic [WIDTH-1:0]  opnd_a,
  input  logic [WIDTH-1:0]  opnd_b,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WIDTH-1:0]  result,
  output logic              flag_z,
  output logic              flag_c,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [MODE_W-1:0] alu_mode,
  output logic              alu_ee,
  output logic              alu_eo,
  input  logic [WIDTH-1:0]  alu_bus,
  input  logic              alu_zero,
  input  logic              alu_carry
);

  // Mode codes shared with the ALU; anything else is rejected without touching it.
  localparam logic [MODE_W-1:0] ALU_ADD  = MODE_W'(0);
  localparam logic [MODE_W-1:0] ALU_ADC  = MODE_W'(1);
  localparam logic [MODE_W-1:0] ALU_SUB  = MODE_W'(2);
  localparam logic [MODE_W-1:0] ALU_INC  = MODE_W'(3);
  localparam logic [MODE_W-1:0] ALU_DEC  = MODE_W'(4);
  localparam logic [MODE_W-1:0] ALU_AND  = MODE_W'(5);
  localparam logic [MODE_W-1:0] ALU_OR   = MODE_W'(6);
  localparam logic [MODE_W-1:0] ALU_XOR  = MODE_W'(7);
  localparam logic [MODE_W-1:0] ALU_SQRT = MODE_W'(8);

  typedef enum logic [2:0] {StIdle, StExec, StCapture, StDone, StErr} state_e;

  state_e            r_state, w_state_d;
  logic              w_op_legal;
  logic [WIDTH-1:0]  r_alu_a, r_alu_b, r_result;
  logic [MODE_W-1:0] r_alu_mode;
  logic              r_flag_z, r_flag_c;

  always_comb begin
    w_op_legal = 1'b0;
    case (op)
      ALU_ADD, ALU_ADC, ALU_SUB, ALU_INC, ALU_DEC,
      ALU_AND, ALU_OR, ALU_XOR, ALU_SQRT: w_op_legal = 1'b1;
      default:                            w_op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    alu_ee    = 1'b0;
    alu_eo    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) w_state_d = w_op_legal ? StExec : StErr;
      end
      StExec: begin
        busy      = 1'b1;
        alu_ee    = 1'b1;
        w_state_d = StCapture;
      end
      StCapture: begin
        busy      = 1'b1;
        alu_ee    = 1'b1;
        alu_eo    = 1'b1;
        w_state_d = StDone;
      end
      StDone: begin
        done      = 1'b1;
        w_state_d = StIdle;
      end
      StErr: begin
        done      = 1'b1;
        err       = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_mode <= '0;
      r_result   <= '0;
      r_flag_z   <= 1'b0;
      r_flag_c   <= 1'b0;
    end else begin
      if (r_state == StIdle && start && w_op_legal) begin
        r_alu_a    <= opnd_a;
        r_alu_b    <= opnd_b;
        r_alu_mode <= op;
      end
      // Bus is only driven by the ALU while alu_eo is high, i.e. in CAPTURE.
      if (r_state == StCapture) begin
        r_result <= alu_bus;
        r_flag_z <= alu_zero;
        r_flag_c <= alu_carry;
      end
    end
  end

  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_mode = r_alu_mode;
  assign result   = r_result;
  assign flag_z   = r_flag_z;
  assign flag_c   = r_flag_c;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 8-bit ALU on the tristate bus.
module tb_alu_sequencer;

  localparam logic [4:0] ADD = 5'd0, ADC = 5'd1, SUB = 5'd2, INC = 5'd3, DEC = 5'd4;
  localparam logic [4:0] AND_ = 5'd5, OR_ = 5'd6, XOR_ = 5'd7, SQRT = 5'd8, BAD = 5'h1F;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [4:0] op;
  logic [7:0] opnd_a, opnd_b;
  logic       busy, done, err, flag_z, flag_c, alu_ee, alu_eo, alu_zero, alu_carry;
  logic [7:0] result, alu_a, alu_b;
  logic [4:0] alu_mode;
  wire  [7:0] alu_bus;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(8), .MODE_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opnd_a(opnd_a), .opnd_b(opnd_b),
    .busy(busy), .done(done), .err(err), .result(result), .flag_z(flag_z),
    .flag_c(flag_c), .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
    .alu_ee(alu_ee), .alu_eo(alu_eo), .alu_bus(alu_bus), .alu_zero(alu_zero),
    .alu_carry(alu_carry)
  );

  // Behavioural ALU: combinational result, bus driven only when enabled.
  logic [8:0] m_res;
  always_comb begin
    m_res = '0;
    case (alu_mode)
      ADD, ADC: m_res = {1'b0, alu_a} + {1'b0, alu_b};
      SUB:      m_res = {1'b0, alu_a} - {1'b0, alu_b};
      INC:      m_res = {1'b0, alu_a} + 9'd1;
      DEC:      m_res = {1'b0, alu_a} - 9'd1;
      AND_:     m_res = {1'b0, alu_a & alu_b};
      OR_:      m_res = {1'b0, alu_a | alu_b};
      XOR_:     m_res = {1'b0, alu_a ^ alu_b};
      SQRT: begin
        for (int i = 0; i < 16; i++)
          if (i * i <= int'(alu_a)) m_res = 9'(i);
      end
      default:  m_res = '0;
    endcase
  end
  assign alu_bus   = (alu_ee && alu_eo) ? m_res[7:0] : 8'bz;
  assign alu_zero  = (m_res[7:0] == 8'h00);
  assign alu_carry = m_res[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues a one-cycle start and walks EXEC/CAPTURE into DONE, checking the handshake.
  task automatic run_op(input logic [4:0] o, input logic [7:0] a, input logic [7:0] b);
    start = 1'b1; op = o; opnd_a = a; opnd_b = b;
    step();
    start = 1'b0; op = BAD; opnd_a = 8'h5A; opnd_b = 8'hA5;
    chk("exec_busy", busy, 1);
    chk("exec_ee_eo", {alu_ee, alu_eo}, 2'b10);
    chk("exec_done", done, 0);
    chk("exec_alu_a", alu_a, a);
    chk("exec_alu_b", alu_b, b);
    chk("exec_mode", alu_mode, o);
    step();
    chk("cap_busy", busy, 1);
    chk("cap_ee_eo", {alu_ee, alu_eo}, 2'b11);
    chk("cap_done", done, 0);
    step();
    chk("done_pulse", {done, err, busy, alu_ee, alu_eo}, 5'b10000);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; opnd_a = '0; opnd_b = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_ctrl", {busy, done, err, alu_ee, alu_eo}, 5'b0);
    chk("rst_data", {result, flag_z, flag_c, alu_a, alu_b, alu_mode}, 0);

    // ADD with carry out
    run_op(ADD, 8'hF0, 8'h20);
    chk("add_res", {result, flag_z, flag_c}, {8'h10, 1'b0, 1'b1});
    step();
    chk("add_idle", {done, busy}, 2'b00);

    // SUB to zero, then SUB with borrow
    run_op(SUB, 8'h05, 8'h05);
    chk("sub0_res", {result, flag_z, flag_c}, {8'h00, 1'b1, 1'b0});
    step();
    run_op(SUB, 8'h03, 8'h05);
    chk("subb_res", {result, flag_z, flag_c}, {8'hFE, 1'b0, 1'b1});
    step();

    // INC wrap
    run_op(INC, 8'hFF, 8'h00);
    chk("inc_res", {result, flag_z, flag_c}, {8'h00, 1'b1, 1'b1});
    step();

    // Second start raised during EXEC must be ignored
    start = 1'b1; op = INC; opnd_a = 8'h10; opnd_b = 8'h00;
    step();
    op = ADD; opnd_a = 8'h77; opnd_b = 8'h11;
    step();
    start = 1'b0;
    chk("ign_cap_busy", busy, 1);
    step();
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) n_done++;
      step();
    end
    chk("ign_one_done", n_done, 1);
    chk("ign_res", {result, flag_z, flag_c}, {8'h11, 1'b0, 1'b0});
    chk("ign_alu_a", alu_a, 8'h10);

    // Illegal op: ERR one cycle after start, ALU untouched
    start = 1'b1; op = BAD; opnd_a = 8'h99; opnd_b = 8'h66;
    step();
    start = 1'b0;
    chk("err_pulse", {done, err, busy, alu_ee, alu_eo}, 5'b11000);
    chk("err_keep", {result, flag_z, flag_c}, {8'h11, 1'b0, 1'b0});
    chk("err_no_load", {alu_a, alu_mode}, {8'h10, INC});
    step();
    chk("err_idle", {done, err, busy, alu_ee, alu_eo}, 5'b0);

    // Reset during CAPTURE of AND aborts with no done
    start = 1'b1; op = AND_; opnd_a = 8'hFF; opnd_b = 8'h0F;
    step();
    start = 1'b0;
    step();
    chk("abort_in_cap", alu_eo, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_ctrl", {busy, done, err, alu_ee, alu_eo}, 5'b0);
    chk("abort_data", {result, flag_z, flag_c, alu_a, alu_b, alu_mode}, 0);
    step();
    chk("abort_no_done", {done, busy}, 2'b00);
    run_op(OR_, 8'h00, 8'h00);
    chk("or_res", {result, flag_z, flag_c}, {8'h00, 1'b1, 1'b0});
    step();

    // Back-to-back XOR with start held: done on every fourth cycle
    start = 1'b1; op = XOR_; opnd_a = 8'hAA; opnd_b = 8'h55;
    step();
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("b2b_done_%0d", k), done, ((k % 4) == 2) ? 1 : 0);
      if ((k % 4) == 2)
        chk($sformatf("b2b_res_%0d", k), {result, flag_z, flag_c}, {8'hFF, 1'b0, 1'b0});
      step();
    end
    start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
